// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands (W = 4*NIBBLES) plus a carry-in, one
// nibble per clock, least-significant nibble first.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - upstream offers an operand pair
//   in_ready   - block accepts an operand pair (IDLE only, low while in reset)
//   a, b       - operands, latched on acceptance
//   cin        - carry into nibble 0, latched with the operands
//   out_valid  - result present (DONE)
//   out_ready  - downstream takes the result
//   sum        - W-bit result word
//   cout       - carry out of the top nibble
//   busy       - high whenever the FSM is not in IDLE
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [4:0]        nib_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Nibble k of the latched operands plus the running carry.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CntW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CntW'(i)) begin
                        sum_d[4*i +: 4] = nib_sum[3:0];
                    end
                end
                carry_d = nib_sum[4];
                if (cnt_q == CntW'(NIBBLES - 1)) begin
                    cout_d  = nib_sum[4];
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // in_ready is gated by rst so it reads low throughout reset.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES = 4). Expected results come from
// plain arithmetic a + b + cin on W+1 bits.
module tb_nibble_serial_adder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total;
    int bad;

    nibble_serial_adder #(
        .NIBBLES(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand pair through the block and reports what was observed.
    // Called at a point away from the rising edge. lat = edges from accept to out_valid
    // (0 if out_valid never appeared), holds = stall cycles where outputs moved,
    // busy_err = busy cycles with in_ready high or busy low, post_ok = IDLE after handshake.
    task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input int stall, output logic [W-1:0] s, output logic c,
                          output int lat, output int holds, output int busy_err,
                          output logic post_ok);
        int guard;
        logic seen;
        guard    = 0;
        holds    = 0;
        busy_err = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a         = ta;
        b         = tb_v;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        // Scramble inputs after acceptance and keep offering a stray pair.
        #1;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        in_valid = 1'($urandom);
        @(negedge clk);
        if (in_ready || !busy) busy_err++;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else if (in_ready || !busy) busy_err++;
        end
        if (!seen) lat = 0;
        in_valid = 1'b0;
        s = sum;
        c = cout;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            if (!out_valid || sum !== s || cout !== c || in_ready) holds++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        post_ok = !out_valid && in_ready && !busy;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy, cout} !== 4'b0000 || sum !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b valid=%b busy=%b cout=%b sum=%h, want 0s",
                     in_ready, out_valid, busy, cout, sum);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
        logic [W-1:0] tb_v [3] = '{16'h4321, 16'h0000, 16'hFFFF};
        logic         tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [3] = '{16'h5555, 16'h0000, 16'hFFFF};
        logic         ec [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] s;
        logic c, post_ok;
        int lat, holds, berr;
        for (int i = 0; i < 3; i++) begin
            do_txn(ta[i], tb_v[i], tc[i], 0, s, c, lat, holds, berr, post_ok);
            total++;
            if (s !== es[i] || c !== ec[i]) begin
                bad++;
                $display("FAIL directed_%0d_result: got %b_%h want %b_%h", i, c, s, ec[i], es[i]);
            end
            total++;
            if (lat != N) begin
                bad++;
                $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, N);
            end
            total++;
            if (!post_ok || berr != 0) begin
                bad++;
                $display("FAIL directed_%0d_handshake: got post_ok=%b busy_err=%0d want 1/0",
                         i, post_ok, berr);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s;
        logic c, post_ok;
        int lat, holds, berr;
        do_txn(16'hABCD, 16'h5678, 1'b1, 5, s, c, lat, holds, berr, post_ok);
        total++;
        if ({c, s} !== 17'h10246) begin
            bad++;
            $display("FAIL backpressure_result: got %b_%h want 1_0246", c, s);
        end
        total++;
        if (holds != 0) begin
            bad++;
            $display("FAIL backpressure_hold: got %0d unstable cycles want 0", holds);
        end
        total++;
        if (!post_ok || lat != N) begin
            bad++;
            $display("FAIL backpressure_release: got post_ok=%b lat=%0d want 1/%0d",
                     post_ok, lat, N);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic c, post_ok;
        int lat, holds, berr;
        a         = 16'h0F0F;
        b         = 16'h7777;
        cin       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        total++;
        if ({in_ready, out_valid, busy, cout} !== 4'b0000 || sum !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got ready=%b valid=%b busy=%b cout=%b sum=%h, want 0s",
                     in_ready, out_valid, busy, cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        do_txn(16'h0001, 16'h0001, 1'b0, 0, s, c, lat, holds, berr, post_ok);
        total++;
        if ({c, s} !== 17'h00002 || lat != N) begin
            bad++;
            $display("FAIL midreset_next: got %b_%h lat=%0d want 0_0002 lat=%0d", c, s, lat, N);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb_v, s;
        logic tc, c, post_ok;
        logic [W:0] exp_v;
        int lat, holds, berr, stall;
        for (int i = 0; i < 1000; i++) begin
            ta    = W'($urandom);
            tb_v  = W'($urandom);
            tc    = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            exp_v = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
            do_txn(ta, tb_v, tc, stall, s, c, lat, holds, berr, post_ok);
            total++;
            if ({c, s} !== exp_v) begin
                bad++;
                $display("FAIL random_%0d_result: %h+%h+%b got %b_%h want %h",
                         i, ta, tb_v, tc, c, s, exp_v);
            end
            total++;
            if (lat != N || holds != 0 || berr != 0 || !post_ok) begin
                bad++;
                $display("FAIL random_%0d_protocol: got lat=%0d holds=%0d busy_err=%0d post=%b want %0d/0/0/1",
                         i, lat, holds, berr, post_ok, N);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 4, the number of 4-bit nibbles per operand (operand width W = 4*NIBBLES; legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, upstream asserts that an operand pair is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit, block can accept an operand pair.
REQ-006 The block SHALL have port a, input, W bits, operand A.
REQ-007 The block SHALL have port b, input, W bits, operand B.
REQ-008 The block SHALL have port cin, input, 1 bit, carry-in for nibble 0, sampled with the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit, result is present.
REQ-010 The block SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-011 The block SHALL have port sum, output, W bits, the result word.
REQ-012 The block SHALL have port cout, output, 1 bit, carry out of the top nibble.
REQ-013 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-015 In IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready the block SHALL latch a, b and cin, clear the nibble counter to 0, and go to ADD.
REQ-016 In ADD: each cycle the block SHALL form {c, s} = A[k] + B[k] + carry_reg, where A[k] and B[k] are nibble k of the latched operands and the result is 5 bits; it SHALL write s into sum nibble k, load c into carry_reg, and increment k.
REQ-017 carry_reg SHALL be loaded from cin at acceptance, so carry_reg = cin for nibble 0.
REQ-018 When the counter reaches NIBBLES-1, the ADD cycle that processes that nibble SHALL load cout from the final carry and move to DONE.
REQ-019 Latency: out_valid SHALL rise exactly NIBBLES clock edges after the accepting edge.
REQ-020 In DONE: out_valid=1, and sum and cout SHALL be held stable; on out_valid&&out_ready the block SHALL return to IDLE.
REQ-021 in_ready SHALL be 0 in ADD and DONE; in_valid SHALL be ignored there. There is no back-to-back overlap: the next accept can occur no earlier than the cycle after the output handshake.
REQ-022 If out_ready is already high when DONE is entered, the handshake SHALL complete in that first DONE cycle, so out_valid is high for exactly 1 cycle.
REQ-023 The result SHALL equal a + b + cin modulo 2^(W+1), split as {cout, sum}; overflow SHALL be reported only through cout.
REQ-024 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-025 sum nibbles not yet processed during ADD are don't-care; only the values while out_valid=1 are defined.

Reset
REQ-026 While rst=1, the block SHALL be held as follows: state=IDLE, counter=0, carry_reg=0, sum=0, cout=0, out_valid=0, busy=0.
REQ-027 While rst=1, in_ready SHALL read 0; after rst deasserts, in_ready SHALL read 1 (IDLE) before the first clock edge.
REQ-028 Reset asserted during ADD or DONE SHALL discard the in-flight operation with no output handshake; the first accept after release SHALL start cleanly from nibble 0.

Verification
REQ-029 Scenario (NIBBLES=4): a=16'h1234, b=16'h4321, cin=0, out_ready=1 -> out_valid 4 cycles after accept, sum=16'h5555, cout=0, out_valid high 1 cycle.
REQ-030 Scenario (full carry ripple): a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
REQ-031 Scenario (overflow): a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
REQ-032 Scenario (back-pressure): out_ready=0 for 5 cycles after DONE, with a and b toggled meanwhile -> out_valid, sum and cout held constant, in_ready=0; on out_ready=1 -> handshake, then IDLE with in_ready=1.
REQ-033 Scenario (reset mid-operation): rst pulsed at the 2nd ADD cycle -> all outputs at reset values; the next operand pair 16'h0001+16'h0001 -> sum=16'h0002, cout=0.
REQ-034 Scenario (random regression): 1000 random a, b, cin values with random out_ready stalls -> every result matches a+b+cin, and in_valid arriving in ADD or DONE is never accepted.
